// File: rtl/rec_fn_pkg.sv
// Shared constants and types for the binary32 <-> recoded-float conversion paths.
package rec_fn_pkg;

    localparam int unsigned F32_EXP_W = 8;
    localparam int unsigned F32_SIG_W = 24;
    localparam int unsigned REC_EXP_W = 9;

    localparam logic [REC_EXP_W-1:0] REC_EXP_ADJ = 9'd129;
    localparam logic [REC_EXP_W-1:0] REC_EXP_INF = 9'h180;
    localparam logic [REC_EXP_W-1:0] REC_EXP_NAN = 9'h1C0;
    localparam logic [F32_SIG_W-2:0] CANON_NAN_FRAC = 23'h400000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } conv_state_t;

    typedef struct packed {
        logic                 sign;
        logic [REC_EXP_W-1:0] exp;
        logic [F32_SIG_W-2:0] frac;
    } rec_f32_t;

endpackage

// File: rtl/window_lzc.sv
// Leading-zero count over a W-bit window, saturating at W when the window is all zero.
module window_lzc #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0]             bits_i,
    output logic [$clog2(W + 1)-1:0] lz_o
);
    localparam int unsigned CW = $clog2(W + 1);

    // Highest set bit wins because it is visited last.
    always_comb begin
        lz_o = CW'(W);
        for (int i = 0; i < int'(W); i++) begin
            if (bits_i[i]) begin
                lz_o = CW'(int'(W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/f32_to_rec_f32_seq.sv
// IEEE binary32 to 33-bit recoded float; subnormals normalised up to SHIFT_STEP bits per cycle.
// Define F32_TO_REC_CANON_NAN_EN to replace every NaN with the canonical quiet NaN.
module f32_to_rec_f32_seq
    import rec_fn_pkg::*;
#(
    parameter int unsigned SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_bits,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [32:0] out_bits
);
    localparam int unsigned FRAC_W = F32_SIG_W - 1;
    localparam int unsigned LZW_W  = $clog2(SHIFT_STEP + 1);
    localparam int unsigned CNT_W  = 5;

    conv_state_t         state_q, state_d;
    rec_f32_t            out_q, out_d, hold_q, hold_d;
    rec_f32_t            conv_c, sub_res_c;
    logic                out_valid_q, out_valid_d;
    logic                sign_q, sign_d;
    logic [FRAC_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, lz_c;
    logic [LZW_W-1:0]    lzw_c;

    logic                in_sign;
    logic [F32_EXP_W-1:0] in_exp;
    logic [FRAC_W-1:0]   in_frac;
    logic                in_is_sub, out_free, accept, window_empty;

    assign {in_sign, in_exp, in_frac} = in_bits;
    assign in_is_sub    = (in_exp == '0) && (in_frac != '0);
    assign out_free     = !out_valid_q || out_ready;
    assign in_ready     = reset && (state_q == IDLE) && out_free;
    assign accept       = in_valid && in_ready;
    assign window_empty = (lzw_c == LZW_W'(SHIFT_STEP));
    assign out_valid    = out_valid_q;
    assign out_bits     = out_q;

    window_lzc #(.W(SHIFT_STEP)) u_lzc (
        .bits_i (work_q[FRAC_W-1 -: SHIFT_STEP]),
        .lz_o   (lzw_c)
    );

    // Single-cycle conversion of normals, zeros, infinities and NaNs.
    always_comb begin
        conv_c.sign = in_sign;
        conv_c.exp  = REC_EXP_W'(in_exp) + REC_EXP_ADJ;
        conv_c.frac = in_frac;
        if (in_exp == '0) begin
            conv_c.exp  = '0;
            conv_c.frac = '0;
        end else if (in_exp == '1) begin
            if (in_frac == '0) begin
                conv_c.exp  = REC_EXP_INF;
                conv_c.frac = '0;
            end else begin
                conv_c.exp = REC_EXP_NAN;
`ifdef F32_TO_REC_CANON_NAN_EN
                conv_c.sign = 1'b0;
                conv_c.frac = CANON_NAN_FRAC;
`endif
            end
        end
    end

    // Result once the leading one sits inside the window; the hidden bit is shifted out.
    always_comb begin
        lz_c           = cnt_q + CNT_W'(lzw_c);
        sub_res_c.sign = sign_q;
        sub_res_c.exp  = REC_EXP_ADJ - REC_EXP_W'(lz_c);
        sub_res_c.frac = (work_q << lzw_c) << 1;
    end

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q && !out_ready;
        hold_d      = hold_q;
        sign_d      = sign_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_is_sub) begin
                        sign_d  = in_sign;
                        work_d  = in_frac;
                        cnt_d   = '0;
                        state_d = NORM;
                    end else begin
                        out_d       = conv_c;
                        out_valid_d = 1'b1;
                    end
                end
            end
            NORM: begin
                if (window_empty) begin
                    work_d = work_q << SHIFT_STEP;
                    cnt_d  = cnt_q + CNT_W'(SHIFT_STEP);
                end else if (out_free) begin
                    out_d       = sub_res_c;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    hold_d  = sub_res_c;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_d       = hold_q;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            hold_q      <= '0;
            sign_q      <= 1'b0;
            work_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            hold_q      <= hold_d;
            sign_q      <= sign_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
